// File: rtl/alu_nibble_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_nibble_seq : WIDTH-bit Y86 add/sub/cmp/and run through one 4-bit slice,
//                  one nibble per cycle, LSB first. Optional abort: ALU_SEQ_ABORT_EN
// Revision 1.0
// ----------------------------------------------------------------------------
module alu_nibble_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
`ifdef ALU_SEQ_ABORT_EN
  input  logic             abort,
`endif
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_y,
  output logic [3:0]       cc
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = $clog2(NIB);
  localparam logic [1:0]    OP_ADD = 2'b00;
  localparam logic [1:0]    OP_SUB = 2'b01;
  localparam logic [1:0]    OP_CMP = 2'b10;
  localparam logic [1:0]    OP_AND = 2'b11;
  localparam logic [IW-1:0] LAST   = IW'(NIB - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       op;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-5:0] acc;
  logic             carry;
  logic [IW-1:0]    idx;
  logic             a_msb;
  logic             b_msb;

  logic             abort_run;
`ifdef ALU_SEQ_ABORT_EN
  assign abort_run = abort;
`else
  assign abort_run = 1'b0;
`endif

  logic             is_sub;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b_eff;
  logic [4:0]       sum5;
  logic [3:0]       nib_out;
  logic             cout;
  logic [WIDTH-1:0] r_full;
  logic             r_zf;
  logic             r_of;
  logic             r_cf;

  // The accumulator holds the nibbles already produced; the current slice
  // output becomes the top nibble, so r_full is the whole result on the last step.
  always_comb begin
    is_sub    = (op == OP_SUB) || (op == OP_CMP);
    nib_a     = a_sr[3:0];
    nib_b_eff = is_sub ? ~b_sr[3:0] : b_sr[3:0];
    sum5      = {1'b0, nib_a} + {1'b0, nib_b_eff} + {4'b0000, carry};
    nib_out   = sum5[3:0];
    cout      = sum5[4];
    if (op == OP_AND) begin
      nib_out = nib_a & b_sr[3:0];
      cout    = 1'b0;
    end
    r_full = {nib_out, acc};
    r_zf   = (r_full == '0);
    r_of   = 1'b0;
    r_cf   = 1'b0;
    case (op)
      OP_ADD: begin
        r_of = (a_msb == b_msb) && (nib_out[3] != a_msb);
        r_cf = cout;
      end
      OP_SUB, OP_CMP: begin
        r_of = (a_msb != b_msb) && (nib_out[3] != a_msb);
        r_cf = ~cout;
      end
      default: begin
        r_of = 1'b0;
        r_cf = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_y     <= '0;
      cc         <= 4'b0000;
      carry      <= 1'b0;
      idx        <= '0;
      op         <= OP_ADD;
      a_sr       <= '0;
      b_sr       <= '0;
      acc        <= '0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            op        <= req_op;
            a_sr      <= req_a;
            b_sr      <= req_b;
            a_msb     <= req_a[WIDTH-1];
            b_msb     <= req_b[WIDTH-1];
            carry     <= (req_op == OP_SUB) || (req_op == OP_CMP);
            idx       <= '0;
            req_ready <= 1'b0;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort_run) begin
            carry     <= 1'b0;
            idx       <= '0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            a_sr  <= a_sr >> 4;
            b_sr  <= b_sr >> 4;
            acc   <= r_full[WIDTH-1:4];
            carry <= cout;
            if (idx == LAST) begin
              resp_y     <= (op == OP_CMP) ? '0 : r_full;
              cc         <= {r_zf, r_full[WIDTH-1], r_of, r_cf};
              resp_valid <= 1'b1;
              state      <= ST_DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_nibble_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_alu_nibble_seq : randomized bench with a behavioural reference model.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_alu_nibble_seq;
  localparam int W   = 64;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [1:0]   req_op = 2'b00;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b1;
  logic [W-1:0] resp_y;
  logic [3:0]   cc;
`ifdef ALU_SEQ_ABORT_EN
  logic         abort = 1'b0;
`endif

  alu_nibble_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef ALU_SEQ_ABORT_EN
    .abort      (abort),
`endif
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_y     (resp_y),
    .cc         (cc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: whole-word arithmetic, signed overflow via one extra bit.
  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] y, output logic [3:0] ccv);
    logic [W:0]        s;
    logic signed [W:0] ss;
    logic [W-1:0]      r;
    logic              of;
    logic              cf;
    s  = '0;
    ss = '0;
    case (op)
      2'b00: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[W-1:0];
        cf = s[W];
        ss = $signed({a[W-1], a}) + $signed({b[W-1], b});
        of = ss[W] != ss[W-1];
      end
      2'b01, 2'b10: begin
        r  = a - b;
        cf = (a < b);
        ss = $signed({a[W-1], a}) - $signed({b[W-1], b});
        of = ss[W] != ss[W-1];
      end
      default: begin
        r  = a & b;
        cf = 1'b0;
        of = 1'b0;
      end
    endcase
    ccv = {(r == '0), r[W-1], of, cf};
    y   = (op == 2'b10) ? '0 : r;
  endfunction

  // Expected interface state, advanced at each rising edge.
  bit           started = 0;
  bit           pending = 0;
  bit           exp_valid = 0;
  int           cnt = 0;
  int           nacc = 0;
  logic [W-1:0] cur_y, hold_y = '0;
  logic [3:0]   cur_cc, hold_cc = 4'b0000;
  logic         ab;

  initial forever begin
    @(posedge clk);
`ifdef ALU_SEQ_ABORT_EN
    ab = abort;
`else
    ab = 1'b0;
`endif
    if (rst) begin
      pending = 0; exp_valid = 0; cnt = 0; hold_y = '0; hold_cc = 4'b0000;
      started = 1;
    end else if (exp_valid) begin
      if (resp_ready) begin exp_valid = 0; pending = 0; end
    end else if (pending) begin
      if (ab) pending = 0;
      else begin
        cnt++;
        if (cnt == NIB) begin exp_valid = 1; hold_y = cur_y; hold_cc = cur_cc; end
      end
    end else if (req_valid) begin
      model(req_op, req_a, req_b, cur_y, cur_cc);
      pending = 1; cnt = 0; nacc++;
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("req_ready",  W'(req_ready),  W'(!pending));
      chk("resp_valid", W'(resp_valid), W'(exp_valid));
      chk("resp_y",     resp_y,         hold_y);
      chk("cc",         W'(cc),         W'(hold_cc));
    end
  end

  // resp_ready modes: 0 always high, 1 random, 2 held low
  int rr_mode = 0;
  initial forever begin
    @(posedge clk); #1;
    case (rr_mode)
      0: resp_ready = 1'b1;
      1: resp_ready = ($urandom_range(2) != 0);
      default: resp_ready = 1'b0;
    endcase
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit keep);
    int n0, t;
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    n0 = nacc; t = 0;
    while (nacc == n0 && t < 300) begin tick(1); t++; end
    checks++;
    if (nacc == n0) begin
      errors++;
      $display("FAIL accept_timeout: waited %0d cycles, required acceptance", t);
    end
    // Scramble inputs after acceptance: the latched copies must be used.
    req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom}; req_op = 2'($urandom);
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((pending || exp_valid) && t < 300) begin tick(1); t++; end
    checks++;
    if (pending || exp_valid) begin
      errors++;
      $display("FAIL drain_timeout: busy after %0d cycles, required idle", t);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(5))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(W-1){1'b0}}};
      3: return {1'b0, {(W-1){1'b1}}};
      4: return W'($urandom_range(15));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  logic [W-1:0] my;
  logic [3:0]   mc;
  int           t;

  initial begin
    // Pin the reference model against hand-computed values.
    model(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, my, mc);
    chk("model_add_of_y", my, 64'h8000_0000_0000_0000); chk("model_add_of_cc", W'(mc), W'(4'b0110));
    model(2'b01, 64'd2, 64'd3, my, mc);
    chk("model_sub_y", my, 64'hFFFF_FFFF_FFFF_FFFF); chk("model_sub_cc", W'(mc), W'(4'b0101));
    model(2'b10, 64'hA, 64'hA, my, mc);
    chk("model_cmp_eq_y", my, 64'd0); chk("model_cmp_eq_cc", W'(mc), W'(4'b1000));
    model(2'b10, 64'hA, 64'hB, my, mc);
    chk("model_cmp_lt_cc", W'(mc), W'(4'b0101));
    model(2'b11, 64'hF0F0, 64'h0FF0, my, mc);
    chk("model_and_y", my, 64'h00F0); chk("model_and_cc", W'(mc), W'(4'b0000));
    model(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, my, mc);
    chk("model_add_wrap_y", my, 64'd0); chk("model_add_wrap_cc", W'(mc), W'(4'b1001));

    tick(3);
    rst = 1'b0;
    tick(1);

    // Directed cases, with an explicit latency check on the first.
    send(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    t = 1;
    while (!resp_valid && t < 40) begin tick(1); t++; end
    chk("latency_edges", W'(t), W'(NIB + 1));
    send(2'b01, 64'd2, 64'd3, 1'b0);
    send(2'b10, 64'hA, 64'hA, 1'b0);
    send(2'b10, 64'hA, 64'hB, 1'b0);
    send(2'b11, 64'hF0F0, 64'h0FF0, 1'b0);
    send(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    drain();

    // Back-pressure: hold resp_ready low 5 cycles while a second request waits.
    rr_mode = 2;
    send(2'b01, 64'h1234, 64'h5678, 1'b0);
    req_op = 2'b00; req_a = 64'h10; req_b = 64'h20; req_valid = 1'b1;
    t = 0;
    while (!exp_valid && t < 40) begin tick(1); t++; end
    tick(5);
    chk("hold_req_ready", W'(req_ready), W'(0));
    chk("hold_resp_valid", W'(resp_valid), W'(1));
    rr_mode = 0;
    send(2'b00, 64'h10, 64'h20, 1'b0);
    drain();

    // Reset in the middle of a run (nibble 7).
    send(2'b00, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    tick(7);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst_req_ready", W'(req_ready), W'(1));
    chk("rst_resp_valid", W'(resp_valid), W'(0));
    chk("rst_y", resp_y, 64'd0);
    chk("rst_cc", W'(cc), W'(4'b0000));

`ifdef ALU_SEQ_ABORT_EN
    send(2'b01, 64'd2, 64'd3, 1'b0);
    drain();
    send(2'b00, 64'd5, 64'd6, 1'b0);
    tick(7);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abort_req_ready", W'(req_ready), W'(1));
    chk("abort_cc_kept", W'(cc), W'(4'b0101));
    // Abort outside RUN has no effect.
    rr_mode = 2;
    send(2'b00, 64'd1, 64'd1, 1'b0);
    while (!exp_valid && t < 40) begin tick(1); t++; end
    abort = 1'b1;
    tick(2);
    abort = 1'b0;
    rr_mode = 0;
    drain();
`endif

    // Randomized traffic with random back-pressure.
    rr_mode = 1;
    for (int i = 0; i < 120; i++) begin
      send(2'($urandom), pick(), pick(), ($urandom_range(1) == 1));
      if ($urandom_range(3) == 0) tick($urandom_range(3));
    end
    req_valid = 1'b0;
    rr_mode = 0;
    drain();
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
